// File: rtl/cmd_frame_if.sv
// Bundle between the host byte stream / payload reader and cmd_frame_parser.
// Stream handshake: a byte transfers on every cycle rx_valid is high; there is no ready, the parser never stalls.
interface cmd_frame_if #(
    parameter int PAYLOAD_ADDR_WIDTH = 8
);
    logic [7:0]                    rx_data;
    logic                          rx_valid;
    logic [PAYLOAD_ADDR_WIDTH-1:0] payload_read_addr;
    logic [7:0]                    payload_read_data;
    logic [7:0]                    cmd_out;
    logic [15:0]                   len_out;
    logic                          parse_done;
    logic                          parse_error;
    logic [1:0]                    error_code;
    logic [2:0]                    state_dbg;

    modport master (
        output rx_data, rx_valid, payload_read_addr,
        input  payload_read_data, cmd_out, len_out, parse_done, parse_error,
               error_code, state_dbg
    );

    modport slave (
        input  rx_data, rx_valid, payload_read_addr,
        output payload_read_data, cmd_out, len_out, parse_done, parse_error,
               error_code, state_dbg
    );
endinterface

// File: rtl/cmd_frame_parser.sv
// Frame recogniser: AA 55 CMD LEN_H LEN_L payload CKSUM, payload stored in a RAM
// with a 2-cycle read port; good/bad frames reported with one-cycle pulses.
module cmd_frame_parser #(
    parameter int          PAYLOAD_ADDR_WIDTH = 8,
    parameter logic [15:0] TIMEOUT_CYCLES     = 16'd50000
) (
    input logic        clk,
    input logic        rst_n,
    cmd_frame_if.slave bus
);
    localparam int          W        = PAYLOAD_ADDR_WIDTH;
    localparam logic [16:0] CAPACITY = 17'd1 << W;

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        CMD   = 3'd2,
        LEN_H = 3'd3,
        LEN_L = 3'd4,
        DATA  = 3'd5,
        CKSUM = 3'd6
    } state_t;

    state_t        state;
    logic [7:0]    temp_cmd;
    logic [15:0]   temp_len;
    logic [7:0]    acc;
    logic [W-1:0]  index;
    logic [15:0]   tcnt;
    logic [7:0]    rd_q;
    logic [7:0]    mem [2**W];

    logic [15:0]   len_full;
    logic          last_byte;

    assign len_full      = {temp_len[15:8], bus.rx_data};
    assign last_byte     = (16'(index) == (temp_len - 16'd1));
    assign bus.state_dbg = state;

    // Payload RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (state == DATA && bus.rx_valid) begin
            mem[index] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= HDR0;
            temp_cmd              <= 8'd0;
            temp_len              <= 16'd0;
            acc                   <= 8'd0;
            index                 <= '0;
            tcnt                  <= 16'd0;
            rd_q                  <= 8'd0;
            bus.payload_read_data <= 8'd0;
            bus.cmd_out           <= 8'd0;
            bus.len_out           <= 16'd0;
            bus.parse_done        <= 1'b0;
            bus.parse_error       <= 1'b0;
            bus.error_code        <= 2'b00;
        end else begin
            bus.parse_done        <= 1'b0;
            bus.parse_error       <= 1'b0;
            // Old data on a same-edge write falls out of non-blocking semantics.
            rd_q                  <= mem[bus.payload_read_addr];
            bus.payload_read_data <= rd_q;

            if (state != HDR0 && !bus.rx_valid) begin
                if (tcnt == TIMEOUT_CYCLES - 16'd1) begin
                    tcnt            <= 16'd0;
                    state           <= HDR0;
                    bus.parse_error <= 1'b1;
                    bus.error_code  <= 2'b11;
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
            end else begin
                tcnt <= 16'd0;
            end

            if (bus.rx_valid) begin
                case (state)
                    HDR0: begin
                        if (bus.rx_data == 8'hAA) state <= HDR1;
                    end
                    HDR1: begin
                        if (bus.rx_data == 8'h55)      state <= CMD;
                        else if (bus.rx_data != 8'hAA) state <= HDR0;
                    end
                    CMD: begin
                        temp_cmd <= bus.rx_data;
                        acc      <= bus.rx_data;
                        state    <= LEN_H;
                    end
                    LEN_H: begin
                        temp_len[15:8] <= bus.rx_data;
                        acc            <= acc + bus.rx_data;
                        state          <= LEN_L;
                    end
                    LEN_L: begin
                        temp_len[7:0] <= bus.rx_data;
                        acc           <= acc + bus.rx_data;
                        index         <= '0;
                        if (len_full == 16'd0) begin
                            state <= CKSUM;
                        end else if ({1'b0, len_full} > CAPACITY) begin
                            state           <= HDR0;
                            bus.parse_error <= 1'b1;
                            bus.error_code  <= 2'b10;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        acc   <= acc + bus.rx_data;
                        index <= index + 1'b1;
                        if (last_byte) state <= CKSUM;
                    end
                    CKSUM: begin
                        state <= HDR0;
                        if (bus.rx_data == acc) begin
                            bus.parse_done <= 1'b1;
                            bus.cmd_out    <= temp_cmd;
                            bus.len_out    <= temp_len;
                        end else begin
                            bus.parse_error <= 1'b1;
                            bus.error_code  <= 2'b01;
                        end
                    end
                    default: state <= HDR0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: frames are driven in sequence, expected
// done/error events are queued at send time and popped by a negedge monitor.
module tb_cmd_frame_parser;
    localparam int          W  = 8;
    localparam logic [15:0] TO = 16'd100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_frame_if #(.PAYLOAD_ADDR_WIDTH(W)) bus ();

    cmd_frame_parser #(
        .PAYLOAD_ADDR_WIDTH(W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Event word: {done, error, error_code, cmd_out, len_out}
    logic [27:0] exp_q [$];
    logic [27:0] mon_exp;
    logic [27:0] mon_obs;
    logic [7:0]  pay [$];
    logic [7:0]  exp_mem [256];
    logic [7:0]  m_cmd = 8'd0;
    logic [15:0] m_len = 16'd0;
    logic [1:0]  m_code = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.parse_done || bus.parse_error)) begin
            mon_obs = {bus.parse_done, bus.parse_error, bus.error_code, bus.cmd_out, bus.len_out};
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_event: observed %h expected no event", mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", 32'(mon_obs), 32'(mon_exp));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    // Sends a frame with payload from pay; ck_xor != 0 corrupts the checksum.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] ck_xor, input int gap);
        logic [15:0] len;
        logic [7:0]  sum;
        len = 16'(pay.size());
        sum = cmd + len[15:8] + len[7:0];
        foreach (pay[i]) sum = sum + pay[i];
        if (ck_xor == 8'd0) begin
            m_cmd = cmd;
            m_len = len;
            exp_q.push_back({1'b1, 1'b0, m_code, m_cmd, m_len});
        end else begin
            m_code = 2'b01;
            exp_q.push_back({1'b0, 1'b1, m_code, m_cmd, m_len});
        end
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(cmd);
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        foreach (pay[i]) begin
            if (gap > 0) idle($urandom_range(0, gap));
            exp_mem[i[7:0]] = pay[i];
            send_byte(pay[i]);
        end
        send_byte(sum ^ ck_xor);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic read_check(input logic [7:0] addr);
        bus.payload_read_addr = addr;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("payload_read", {24'd0, bus.payload_read_data}, {24'd0, exp_mem[addr]});
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cmd"}, {24'd0, bus.cmd_out}, 32'd0);
        check({tag, "_len"}, {16'd0, bus.len_out}, 32'd0);
        check({tag, "_pulses"}, {30'd0, bus.parse_done, bus.parse_error}, 32'd0);
        check({tag, "_code"}, {30'd0, bus.error_code}, 32'd0);
        check({tag, "_data"}, {24'd0, bus.payload_read_data}, 32'd0);
        check({tag, "_state"}, {29'd0, bus.state_dbg}, 32'd0);
    endtask

    initial begin
        bus.rx_data           = 8'd0;
        bus.rx_valid          = 1'b0;
        bus.payload_read_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Zero-length frame
        pay = {};
        send_frame(8'hFF, 8'h00, 0);
        drain("t1_drain", 20);
        check("t1_cmd", {24'd0, bus.cmd_out}, 32'h0000_00FF);
        check("t1_len", {16'd0, bus.len_out}, 32'd0);

        // Back-to-back three-byte frame, checksum 0x19
        pay = {8'h01, 8'h02, 8'h03};
        send_frame(8'h10, 8'h00, 0);
        drain("t2_drain", 20);
        check("t2_len", {16'd0, bus.len_out}, 32'd3);
        for (int a = 0; a < 3; a++) read_check(8'(a));
        idle(1);
        check("t2_read_stable", {24'd0, bus.payload_read_data}, 32'h0000_0003);

        // Same frame with checksum 0x18
        send_frame(8'h10, 8'h01, 0);
        drain("t3_drain", 20);
        check("t3_code", {30'd0, bus.error_code}, 32'd1);
        check("t3_cmd_held", {24'd0, bus.cmd_out}, 32'h0000_0010);

        // Garbage then AA AA 55 resync
        send_byte(8'h13);
        send_byte(8'h37);
        send_byte(8'hAA);
        pay = {};
        send_frame(8'h20, 8'h00, 0);
        drain("t4_drain", 20);
        check("t4_cmd", {24'd0, bus.cmd_out}, 32'h0000_0020);

        // Length 257 overflows a 256-byte RAM
        m_code = 2'b10;
        exp_q.push_back({1'b0, 1'b1, m_code, m_cmd, m_len});
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h30);
        send_byte(8'h01);
        send_byte(8'h01);
        drain("t5_overflow_drain", 20);
        check("t5_code", {30'd0, bus.error_code}, 32'd2);

        // Random payload with idle gaps, then a frame that fills the RAM exactly
        pay = {};
        for (int i = 0; i < 5; i++) pay.push_back(8'($urandom_range(0, 255)));
        send_frame(8'($urandom_range(0, 255)), 8'h00, 3);
        drain("t5_rand_drain", 20);
        for (int a = 0; a < 5; a++) read_check(8'(a));
        pay = {};
        for (int i = 0; i < 256; i++) pay.push_back(8'($urandom_range(0, 255)));
        send_frame(8'h77, 8'h00, 0);
        drain("t5_full_drain", 20);
        check("t5_full_len", {16'd0, bus.len_out}, 32'd256);
        read_check(8'd0);
        read_check(8'd255);

        // Timeout after a stalled header
        m_code = 2'b11;
        exp_q.push_back({1'b0, 1'b1, m_code, m_cmd, m_len});
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h40);
        idle(90);
        check("t6_timeout_early", 32'(exp_q.size()), 32'd1);
        drain("t6_timeout_drain", 50);
        check("t6_code", {30'd0, bus.error_code}, 32'd3);

        // Reset mid-frame
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h41);
        send_byte(8'h00);
        rst_n = 1'b0;
        idle(2);
        check_zero_outputs("midreset");
        m_cmd  = 8'd0;
        m_len  = 16'd0;
        m_code = 2'b00;
        rst_n  = 1'b1;
        idle(2);
        pay = {8'h09};
        send_frame(8'h42, 8'h00, 0);
        drain("t6_after_reset_drain", 20);
        check("t6_after_reset_cmd", {24'd0, bus.cmd_out}, 32'h0000_0042);
        check("t6_after_reset_len", {16'd0, bus.len_out}, 32'd1);
        read_check(8'd0);

        idle(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
